// File: rtl/mc_main_control_if.sv
// Bundles the main-control handshake and datapath enables between the controller and the datapath/memory side.
interface mc_main_control_if;
   logic [5:0] opcode;
   logic       jump_reg;
   logic       mem_ready;
   logic       mem_req;
   logic       memwrite;
   logic       iord;
   logic       irwrite;
   logic       pcwrite;
   logic       pcwritecond;
   logic [1:0] pcsource;
   logic       regwrite;
   logic [1:0] regdst;
   logic [1:0] memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [2:0] aluop;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  opcode, jump_reg, mem_ready,
      output mem_req, memwrite, iord, irwrite, pcwrite, pcwritecond, pcsource,
             regwrite, regdst, memtoreg, alusrca, alusrcb, aluop, illegal_op, state
   );

   modport slave (
      output opcode, jump_reg, mem_ready,
      input  mem_req, memwrite, iord, irwrite, pcwrite, pcwritecond, pcsource,
             regwrite, regdst, memtoreg, alusrca, alusrcb, aluop, illegal_op, state
   );
endinterface

// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback sequencing with a req/ready memory handshake.
module mc_main_control (
   input  logic                clk,
   input  logic                reset,
   mc_main_control_if.master   bus
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWR  = 4'd5,
      S_MEMWB  = 4'd6,
      S_RTEX   = 4'd7,
      S_RTWB   = 4'd8,
      S_BEQ    = 4'd9,
      S_BLEZ   = 4'd10,
      S_ITEX   = 4'd11,
      S_ITWB   = 4'd12,
      S_JMP    = 4'd13,
      S_JAL    = 4'd14,
      S_BAD    = 4'd15
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BLEZ = 6'b000110;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       iord;
      logic       pcwrite;
      logic       pcwritecond;
      logic [1:0] pcsource;
      logic       regwrite;
      logic [1:0] regdst;
      logic [1:0] memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluop;
   } ctrl_t;

   state_t     state_q;
   state_t     state_next;
   logic [5:0] op_q;
   logic [5:0] op_next;
   ctrl_t      ctrl_q;
   logic       in_fetch;
   logic       jr_fire;

   function automatic state_t decode_target(input logic [5:0] op);
      state_t t;
      case (op)
         OP_R:                     t = S_RTEX;
         OP_LW, OP_SW:             t = S_MEMADR;
         OP_BEQ:                   t = S_BEQ;
         OP_BLEZ:                  t = S_BLEZ;
         OP_ADDI, OP_ANDI, OP_ORI: t = S_ITEX;
         OP_J:                     t = S_JMP;
         OP_JAL:                   t = S_JAL;
         default:                  t = S_FETCH;
      endcase
      return t;
   endfunction

   // Moore control word for a state; the opcode selects the ALU op in ITEX only.
   function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req = 1'b1;
            c.alusrcb = 2'b01;
         end
         S_DECODE: c.alusrcb = 2'b11;
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         S_MEMRD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWR: begin
            c.mem_req  = 1'b1;
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEMWB: begin
            c.memtoreg = 2'b01;
            c.regwrite = 1'b1;
         end
         S_RTEX: begin
            c.alusrca = 1'b1;
            c.aluop   = 3'b100;
         end
         S_RTWB: begin
            c.regdst   = 2'b01;
            c.regwrite = 1'b1;
         end
         S_BEQ: begin
            c.alusrca     = 1'b1;
            c.aluop       = 3'b001;
            c.pcwritecond = 1'b1;
            c.pcsource    = 2'b01;
         end
         S_BLEZ: begin
            c.alusrca     = 1'b1;
            c.aluop       = 3'b101;
            c.pcwritecond = 1'b1;
            c.pcsource    = 2'b01;
         end
         S_ITEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            case (op)
               OP_ANDI: c.aluop = 3'b010;
               OP_ORI:  c.aluop = 3'b011;
               default: c.aluop = 3'b000;
            endcase
         end
         S_ITWB: c.regwrite = 1'b1;
         S_JMP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = 2'b10;
         end
         S_JAL: begin
            c.pcwrite  = 1'b1;
            c.pcsource = 2'b10;
            c.regdst   = 2'b10;
            c.memtoreg = 2'b10;
            c.regwrite = 1'b1;
            c.aluop    = 3'b110;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      op_next    = (state_q == S_DECODE) ? bus.opcode : op_q;
      state_next = S_FETCH;
      case (state_q)
         S_IDLE:   state_next = S_FETCH;
         S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: state_next = decode_target(bus.opcode);
         S_MEMADR: state_next = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_RTEX:   state_next = bus.jump_reg ? S_FETCH : S_RTWB;
         S_ITEX:   state_next = S_ITWB;
         default:  state_next = S_FETCH;
      endcase
   end

   // The control word is registered from the next state so it is already valid on state entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_next;
         op_q    <= op_next;
         ctrl_q  <= ctrl_of(state_next, op_next);
      end
   end

   // Handshake-qualified enables and jr need the current-cycle inputs, so they stay combinational.
   always_comb begin
      in_fetch         = (state_q == S_FETCH);
      jr_fire          = (state_q == S_RTEX) && bus.jump_reg;
      bus.mem_req      = ctrl_q.mem_req;
      bus.memwrite     = ctrl_q.memwrite;
      bus.iord         = ctrl_q.iord;
      bus.irwrite      = in_fetch && bus.mem_ready;
      bus.pcwrite      = ctrl_q.pcwrite || (in_fetch && bus.mem_ready) || jr_fire;
      bus.pcwritecond  = ctrl_q.pcwritecond;
      bus.pcsource     = jr_fire ? 2'b11 : ctrl_q.pcsource;
      bus.regwrite     = ctrl_q.regwrite && ((state_q != S_MEMWB) || bus.mem_ready);
      bus.regdst       = ctrl_q.regdst;
      bus.memtoreg     = ctrl_q.memtoreg;
      bus.alusrca      = ctrl_q.alusrca;
      bus.alusrcb      = ctrl_q.alusrcb;
      bus.aluop        = ctrl_q.aluop;
      bus.illegal_op   = (state_q == S_DECODE) && (decode_target(bus.opcode) == S_FETCH);
      bus.state        = state_q;
   end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed, table-driven check of the main control FSM state sequence and per-state control outputs.
module tb_mc_main_control;

   logic clk = 1'b0;
   logic reset;

   mc_main_control_if bus ();

   mc_main_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic        jr;
      logic        rdy;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   passed = 0;
   int   total  = 0;

   logic [23:0] act;
   assign act = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.pcwrite,
                 bus.pcwritecond, bus.pcsource, bus.regwrite, bus.regdst, bus.memtoreg,
                 bus.alusrca, bus.alusrcb, bus.aluop, bus.illegal_op, bus.state};

   // Expected word in the same bit order as act.
   function automatic vec_t mk(input string nm, input logic [5:0] op, input logic jr,
                               input logic rdy, input logic [3:0] st, input logic mr,
                               input logic mw, input logic io, input logic irw,
                               input logic pcw, input logic pcwc, input logic [1:0] pcs,
                               input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                               input logic asa, input logic [1:0] asb,
                               input logic [2:0] aop, input logic ill);
      vec_t v;
      v.name = nm;
      v.op   = op;
      v.jr   = jr;
      v.rdy  = rdy;
      v.exp  = {mr, mw, io, irw, pcw, pcwc, pcs, rw, rd, m2r, asa, asb, aop, ill, st};
      return v;
   endfunction

   function automatic vec_t fetch_row(input string nm, input logic [5:0] op, input logic jr);
      return mk(nm, op, jr, 1'b1, 4'd1, 1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 3'b000, 0);
   endfunction

   function automatic vec_t dec_row(input string nm, input logic [5:0] op, input logic jr);
      return mk(nm, op, jr, 1'b1, 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b11, 3'b000, 0);
   endfunction

   function automatic vec_t zero_row(input string nm, input logic rdy);
      return mk(nm, 6'h00, 1'b0, rdy, 4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0);
   endfunction

   // Drive one cycle's inputs, compare mid-cycle, then advance past the next rising edge.
   task automatic apply(input vec_t v);
      bus.opcode    = v.op;
      bus.jump_reg  = v.jr;
      bus.mem_ready = v.rdy;
      #2;
      total = total + 1;
      if (act === v.exp) passed = passed + 1;
      else $display("FAIL %s: got %06h expected %06h", v.name, act, v.exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      bus.opcode    = 6'h00;
      bus.jump_reg  = 1'b0;
      bus.mem_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;

      // add
      tbl.push_back(fetch_row("add fetch", 6'h00, 0));
      tbl.push_back(dec_row("add decode", 6'h00, 0));
      tbl.push_back(mk("add rtex", 6'h00, 0, 1, 4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 3'b100, 0));
      tbl.push_back(mk("add rtwb", 6'h00, 0, 1, 4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 3'b000, 0));
      // jr
      tbl.push_back(fetch_row("jr fetch", 6'h00, 1));
      tbl.push_back(dec_row("jr decode", 6'h00, 1));
      tbl.push_back(mk("jr rtex", 6'h00, 1, 1, 4'd7, 0, 0, 0, 0, 1, 0, 2'b11, 0, 2'b00, 2'b00, 1, 2'b00, 3'b100, 0));
      // lw; opcode changed after decode must not redirect to MEMWR
      tbl.push_back(fetch_row("lw fetch", 6'h23, 0));
      tbl.push_back(dec_row("lw decode", 6'h23, 0));
      tbl.push_back(mk("lw memadr", 6'h2B, 0, 1, 4'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
      tbl.push_back(mk("lw memrd", 6'h2B, 0, 1, 4'd4, 1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      tbl.push_back(mk("lw memwb", 6'h23, 0, 1, 4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 2'b00, 3'b000, 0));
      // sw
      tbl.push_back(fetch_row("sw fetch", 6'h2B, 0));
      tbl.push_back(dec_row("sw decode", 6'h2B, 0));
      tbl.push_back(mk("sw memadr", 6'h2B, 0, 1, 4'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
      tbl.push_back(mk("sw memwr", 6'h2B, 0, 1, 4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      // beq / blez
      tbl.push_back(fetch_row("beq fetch", 6'h04, 0));
      tbl.push_back(dec_row("beq decode", 6'h04, 0));
      tbl.push_back(mk("beq exec", 6'h04, 0, 1, 4'd9, 0, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 1, 2'b00, 3'b001, 0));
      tbl.push_back(fetch_row("blez fetch", 6'h06, 0));
      tbl.push_back(dec_row("blez decode", 6'h06, 0));
      tbl.push_back(mk("blez exec", 6'h06, 0, 1, 4'd10, 0, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 1, 2'b00, 3'b101, 0));
      // immediates; andi ITEX sees a different live opcode
      tbl.push_back(fetch_row("addi fetch", 6'h08, 0));
      tbl.push_back(dec_row("addi decode", 6'h08, 0));
      tbl.push_back(mk("addi itex", 6'h08, 0, 1, 4'd11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
      tbl.push_back(mk("addi itwb", 6'h08, 0, 1, 4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      tbl.push_back(fetch_row("andi fetch", 6'h0C, 0));
      tbl.push_back(dec_row("andi decode", 6'h0C, 0));
      tbl.push_back(mk("andi itex", 6'h08, 0, 1, 4'd11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 3'b010, 0));
      tbl.push_back(mk("andi itwb", 6'h0C, 0, 1, 4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      tbl.push_back(fetch_row("ori fetch", 6'h0D, 0));
      tbl.push_back(dec_row("ori decode", 6'h0D, 0));
      tbl.push_back(mk("ori itex", 6'h0D, 0, 1, 4'd11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 3'b011, 0));
      tbl.push_back(mk("ori itwb", 6'h0D, 0, 1, 4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      // jumps
      tbl.push_back(fetch_row("j fetch", 6'h02, 0));
      tbl.push_back(dec_row("j decode", 6'h02, 0));
      tbl.push_back(mk("j exec", 6'h02, 0, 1, 4'd13, 0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      tbl.push_back(fetch_row("jal fetch", 6'h03, 0));
      tbl.push_back(dec_row("jal decode", 6'h03, 0));
      tbl.push_back(mk("jal exec", 6'h03, 0, 1, 4'd14, 0, 0, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b10, 0, 2'b00, 3'b110, 0));
      // illegal opcode
      tbl.push_back(fetch_row("ill fetch", 6'h3F, 0));
      tbl.push_back(mk("ill decode", 6'h3F, 0, 1, 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b11, 3'b000, 1));

      apply(zero_row("reset held", 1'b1));
      reset = 1'b0;
      apply(zero_row("idle", 1'b1));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Fetch stall: no IR/PC load until ready, then exactly one pulse.
      for (int i = 0; i < 5; i++)
         apply(mk("fetch stall", 6'h23, 0, 0, 4'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 3'b000, 0));
      apply(fetch_row("fetch ready", 6'h23, 0));
      apply(dec_row("stall decode", 6'h23, 0));

      // lw with MEMRD stalled three cycles.
      apply(mk("stall memadr", 6'h23, 0, 1, 4'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
      for (int i = 0; i < 3; i++)
         apply(mk("memrd stall", 6'h23, 0, 0, 4'd4, 1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      apply(mk("memrd ready", 6'h23, 0, 1, 4'd4, 1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      apply(mk("stall memwb", 6'h23, 0, 1, 4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 2'b00, 3'b000, 0));

      // sw interrupted by reset while waiting in MEMWR.
      apply(fetch_row("rsw fetch", 6'h2B, 0));
      apply(dec_row("rsw decode", 6'h2B, 0));
      apply(mk("rsw memadr", 6'h2B, 0, 1, 4'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
      apply(mk("rsw memwr", 6'h2B, 0, 0, 4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      reset = 1'b1;
      apply(mk("rsw memwr rst", 6'h2B, 0, 0, 4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
      apply(zero_row("rsw idle", 1'b0));
      reset = 1'b0;
      apply(zero_row("post idle", 1'b1));
      apply(fetch_row("post fetch", 6'h00, 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
